// File: rtl/cpu_core.sv
// Multi-cycle 32-bit load/store core sharing one synchronous-read memory port.
// Optional multiplier for opcode 12 is enabled by defining CPU_MUL_EN.
module cpu_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK_I,
    input  logic              RES_I,
    input  logic [ADDR_W-1:0] ADR_I,
    output logic [ADDR_W-1:0] ADR_O,
    input  logic [DATA_W-1:0] DAT_I,
    output logic [DATA_W-1:0] DAT_O,
    output logic              STB_O,
    output logic              WE_O,
    output logic              HALT_O
);

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_EXEC, S_MEM, S_LDWB, S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t              state_reg;
    logic [DATA_W-1:0]   regs_reg [0:15];
    logic [ADDR_W-1:0]   pc_reg;
    logic [3:0]          ld_rd_reg;
    logic                is_st_reg;

    logic [3:0]          op, rd, rs1, rs2;
    logic [DATA_W-1:0]   imm_sext, rs1_val, rs2_val;
    logic [ADDR_W-1:0]   pc_plus4, ea_aligned;
    logic [ADDR_W-1:0]   pc_next;
    logic [DATA_W-1:0]   wb_next;
    logic                wb_en_next;

    assign op       = DAT_I[31:28];
    assign rd       = DAT_I[27:24];
    assign rs1      = DAT_I[23:20];
    assign rs2      = DAT_I[19:16];
    assign imm_sext = {{16{DAT_I[15]}}, DAT_I[15:0]};
    assign rs1_val  = regs_reg[rs1];
    assign rs2_val  = regs_reg[rs2];
    assign pc_plus4 = pc_reg + ADDR_W'(4);
    assign ea_aligned = ADDR_W'(rs1_val + imm_sext) & ALIGN_MASK;

    // Write-back value and next PC for every single-cycle EXEC instruction.
    always_comb begin
        pc_next    = pc_plus4;
        wb_next    = '0;
        wb_en_next = 1'b0;
        case (op)
            4'd1: begin wb_next = rs1_val + rs2_val;   wb_en_next = 1'b1; end
            4'd2: begin wb_next = rs1_val - rs2_val;   wb_en_next = 1'b1; end
            4'd3: begin wb_next = rs1_val & rs2_val;   wb_en_next = 1'b1; end
            4'd4: begin wb_next = rs1_val | rs2_val;   wb_en_next = 1'b1; end
            4'd5: begin wb_next = rs1_val ^ rs2_val;   wb_en_next = 1'b1; end
            4'd6: begin wb_next = rs1_val + imm_sext;  wb_en_next = 1'b1; end
            4'd7: begin wb_next = {DAT_I[15:0], 16'h0}; wb_en_next = 1'b1; end
            4'd10: begin
                if (rs1_val == rs2_val)
                    pc_next = pc_reg + ADDR_W'(imm_sext << 2);
            end
            4'd11: begin
                wb_next    = DATA_W'(pc_plus4);
                wb_en_next = 1'b1;
                pc_next    = ADDR_W'(rs1_val + imm_sext);
            end
`ifdef CPU_MUL_EN
            4'd12: begin wb_next = rs1_val * rs2_val;  wb_en_next = 1'b1; end
`else
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RES_I) begin
        if (!RES_I) begin
            state_reg <= S_BOOT;
            pc_reg    <= '0;
            ADR_O     <= '0;
            DAT_O     <= '0;
            STB_O     <= 1'b0;
            WE_O      <= 1'b0;
            HALT_O    <= 1'b0;
            ld_rd_reg <= '0;
            is_st_reg <= 1'b0;
            for (int i = 0; i < 16; i++)
                regs_reg[i] <= '0;
        end else begin
            case (state_reg)
                S_BOOT: begin
                    pc_reg    <= ADR_I & ALIGN_MASK;
                    ADR_O     <= ADR_I & ALIGN_MASK;
                    STB_O     <= 1'b1;
                    WE_O      <= 1'b0;
                    state_reg <= S_FETCH;
                end
                S_FETCH: begin
                    STB_O     <= 1'b0;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == 4'd8 || op == 4'd9) begin
                        ADR_O     <= ea_aligned;
                        STB_O     <= 1'b1;
                        WE_O      <= (op == 4'd9);
                        if (op == 4'd9)
                            DAT_O <= rs2_val;
                        ld_rd_reg <= rd;
                        is_st_reg <= (op == 4'd9);
                        state_reg <= S_MEM;
                    end else if (op == 4'd15) begin
                        HALT_O    <= 1'b1;
                        state_reg <= S_HALT;
                    end else begin
                        if (wb_en_next && rd != 4'd0)
                            regs_reg[rd] <= wb_next;
                        pc_reg    <= pc_next;
                        ADR_O     <= pc_next & ALIGN_MASK;
                        STB_O     <= 1'b1;
                        state_reg <= S_FETCH;
                    end
                end
                S_MEM: begin
                    WE_O <= 1'b0;
                    if (is_st_reg) begin
                        pc_reg    <= pc_plus4;
                        ADR_O     <= pc_plus4 & ALIGN_MASK;
                        STB_O     <= 1'b1;
                        state_reg <= S_FETCH;
                    end else begin
                        // Load data arrives next cycle; bus idles meanwhile.
                        STB_O     <= 1'b0;
                        state_reg <= S_LDWB;
                    end
                end
                S_LDWB: begin
                    if (ld_rd_reg != 4'd0)
                        regs_reg[ld_rd_reg] <= DAT_I;
                    pc_reg    <= pc_plus4;
                    ADR_O     <= pc_plus4 & ALIGN_MASK;
                    STB_O     <= 1'b1;
                    state_reg <= S_FETCH;
                end
                S_HALT: begin
                    STB_O <= 1'b0;
                    WE_O  <= 1'b0;
                end
                default: state_reg <= S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: behavioural memory, write/read logs, hand-computed checks.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr_i = 32'h0;
    logic [31:0] adr_o, dat_o;
    logic [31:0] dat_i = 32'h0;
    logic        stb_o, we_o, halt_o;

    logic [31:0] prog [0:127];
    logic [31:0] mem  [0:127];
    logic        load = 1'b0;
    logic        clr  = 1'b0;

    logic [31:0] wr_a [0:7];
    logic [31:0] wr_d [0:7];
    logic [31:0] wr_c [0:7];
    int          wr_n;
    logic [31:0] rd_a [0:63];
    int          rd_n;
    logic [31:0] cyc;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_core dut (
        .CLK_I  (clk),
        .RES_I  (rst_n),
        .ADR_I  (adr_i),
        .ADR_O  (adr_o),
        .DAT_I  (dat_i),
        .DAT_O  (dat_o),
        .STB_O  (stb_o),
        .WE_O   (we_o),
        .HALT_O (halt_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load)
            mem <= prog;
        else if (stb_o && we_o)
            mem[adr_o[8:2]] <= dat_o;
        if (stb_o && !we_o)
            dat_i <= mem[adr_o[8:2]];
        if (!rst_n)
            cyc <= 32'd0;
        else
            cyc <= cyc + 32'd1;
        if (clr) begin
            wr_n <= 0;
            rd_n <= 0;
        end else begin
            if (stb_o && we_o && wr_n < 8) begin
                wr_a[wr_n] <= adr_o;
                wr_d[wr_n] <= dat_o;
                wr_c[wr_n] <= cyc;
                wr_n <= wr_n + 1;
            end
            if (stb_o && !we_o && rd_n < 64) begin
                rd_a[rd_n] <= adr_o;
                rd_n <= rd_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] ins);
        prog[a[8:2]] = ins;
    endtask

    // Hold reset for two cycles, reload memory and clear the logs.
    task automatic hold_reset(input logic [31:0] boot);
        @(negedge clk);
        rst_n = 1'b0;
        adr_i = boot;
        load  = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load  = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 100 && !halt_o; i++) @(negedge clk);
        chk(tag, {31'h0, halt_o}, 32'h1);
    endtask

    initial begin
        // ---------------- boot and ALU (ADD) ----------------
        clear_prog();
        put(32'h100, 32'h61000005);  // ADDI r1,r0,5
        put(32'h104, 32'h6200FFFD);  // ADDI r2,r0,-3
        put(32'h108, 32'h13120000);  // ADD r3,r1,r2
        put(32'h10C, 32'h90030040);  // ST r3 -> [0x40]
        put(32'h110, 32'hF0000000);  // HALT
        hold_reset(32'h103);
        chk("rst_adr", adr_o, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_ctl", {29'h0, stb_o, we_o, halt_o}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("boot_idle_stb", {31'h0, stb_o}, 32'h0);
        @(negedge clk);
        chk("boot_adr", adr_o, 32'h100);
        chk("boot_ctl", {30'h0, stb_o, we_o}, 32'h2);
        wait_halt("add_halt");
        chk("add_wr_n", wr_n, 32'd1);
        chk("add_wr_a", wr_a[0], 32'h40);
        chk("add_wr_d", wr_d[0], 32'h2);
        chk("add_wr_c", wr_c[0], 32'd9);
        $display("add test: addr %h data %h cycle %0d", wr_a[0], wr_d[0], wr_c[0]);

        // ---------------- ALU (SUB) ----------------
        put(32'h108, 32'h23120000);  // SUB r3,r1,r2
        hold_reset(32'h100);
        rst_n = 1'b1;
        wait_halt("sub_halt");
        chk("sub_wr_d", wr_d[0], 32'h8);
        $display("sub test: addr %h data %h", wr_a[0], wr_d[0]);

        // ---------------- load / store ----------------
        clear_prog();
        put(32'h100, 32'h7100DEAD);  // LUI r1,0xDEAD
        put(32'h104, 32'h62005EEF);  // ADDI r2,r0,0x5EEF
        put(32'h108, 32'h62206000);  // ADDI r2,r2,0x6000
        put(32'h10C, 32'h41120000);  // OR r1,r1,r2
        put(32'h110, 32'h90010080);  // ST r1 -> [0x80]
        put(32'h114, 32'h84000080);  // LD r4 <- [0x80]
        put(32'h118, 32'h90040086);  // ST r4 -> [0x86] (aligned to 0x84)
        put(32'h11C, 32'hF0000000);
        hold_reset(32'h100);
        rst_n = 1'b1;
        wait_halt("ls_halt");
        chk("ls_wr_n", wr_n, 32'd2);
        chk("ls_st1_c", wr_c[0], 32'd11);
        chk("ls_st2_a", wr_a[1], 32'h84);
        chk("ls_st2_d", wr_d[1], 32'hDEADBEEF);
        chk("ls_st2_c", wr_c[1], 32'd18);
        $display("ld/st test: addr %h data %h cycle %0d", wr_a[1], wr_d[1], wr_c[1]);

        // ---------------- branch / jump / r0 / MUL ----------------
        clear_prog();
        put(32'h100, 32'h61000007);  // ADDI r1,r0,7
        put(32'h104, 32'h62000007);  // ADDI r2,r0,7
        put(32'h108, 32'hA0120002);  // BEQ r1,r2,+2 (taken)
        put(32'h10C, 32'h90010040);  // skipped store
        put(32'h110, 32'h63000009);  // ADDI r3,r0,9
        put(32'h114, 32'hA0130002);  // BEQ r1,r3,+2 (not taken)
        put(32'h118, 32'hB5000120);  // JAL r5, r0+0x120
        put(32'h11C, 32'hF0000000);  // skipped HALT
        put(32'h120, 32'h60000005);  // ADDI r0,r0,5
        put(32'h124, 32'h90050040);  // ST r5 -> [0x40]
        put(32'h128, 32'h90000044);  // ST r0 -> [0x44]
        put(32'h12C, 32'h66000001);  // ADDI r6,r0,1
        put(32'h130, 32'h62000006);  // ADDI r2,r0,6
        put(32'h134, 32'hC6120000);  // MUL r6,r1,r2
        put(32'h138, 32'h90060048);  // ST r6 -> [0x48]
        put(32'h13C, 32'hF0000000);
        hold_reset(32'h100);
        rst_n = 1'b1;
        wait_halt("br_halt");
        chk("beq_taken", rd_a[3], 32'h110);
        chk("beq_not_taken", rd_a[5], 32'h118);
        chk("jal_target", rd_a[6], 32'h120);
        chk("br_wr_n", wr_n, 32'd3);
        chk("jal_link", wr_d[0], 32'h11C);
        chk("r0_zero", wr_d[1], 32'h0);
`ifdef CPU_MUL_EN
        chk("mul", wr_d[2], 32'd42);
`else
        chk("mul_nop", wr_d[2], 32'd1);
`endif
        chk("mul_wr_c", wr_c[2], 32'd29);
        $display("branch test: jal link %h r0 %h mul %0d", wr_d[0], wr_d[1], wr_d[2]);

        // ---------------- HALT keeps bus quiet ----------------
        begin
            logic any_stb;
            any_stb = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                any_stb = any_stb | stb_o;
            end
            chk("halt_no_stb", {31'h0, any_stb}, 32'h0);
            chk("halt_held", {31'h0, halt_o}, 32'h1);
            chk("halt_no_wr", wr_n, 32'd3);
        end

        // ---------------- reset during ST MEM ----------------
        clear_prog();
        put(32'h180, 32'h61000055);  // ADDI r1,r0,0x55
        put(32'h184, 32'h90010050);  // ST r1 -> [0x50]
        put(32'h188, 32'hF0000000);
        hold_reset(32'h180);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mem_we", {30'h0, stb_o, we_o}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", {30'h0, stb_o, we_o}, 32'h0);
        chk("abort_adr", adr_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_wr", wr_n, 32'd0);
        chk("abort_mem", mem[20], 32'h0);
        rst_n = 1'b1;
        wait_halt("reboot_halt");
        chk("reboot_fetch", rd_a[2], 32'h180);
        chk("reboot_wr_n", wr_n, 32'd1);
        chk("reboot_wr_d", wr_d[0], 32'h55);
        $display("reset test: writes %0d data %h", wr_n, wr_d[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
